// File: rtl/flit_merge_arbiter.sv
// flit_merge_arbiter
// Merges two flit streams onto one registered output channel. Arbitration is
// round-robin at packet granularity: the winning input keeps the output until
// its tail flit (bit W-1 set) has been accepted. Every output flit is tagged
// with the input it came from. Latency is one cycle and throughput is one
// flit per cycle.
//
// Ports:
//   CLK                  clock, all state changes on the rising edge
//   RESET                synchronous active-high reset
//   in0_data/valid/ready input 0 flit channel
//   in1_data/valid/ready input 1 flit channel
//   out_data             registered output flit
//   out_src              input index that produced out_data
//   out_valid/out_ready  output channel handshake
//   busy                 high while a packet holds the output (not IDLE)
module flit_merge_arbiter #(
    parameter int W       = 9,
    parameter bit RR_INIT = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         prio;
    logic         prio_next;
    logic         adv;
    logic         grant_valid;
    logic         grant_idx;
    logic         xfer;
    logic [W-1:0] grant_data;

    // The output register can take a new flit when it is empty or draining.
    assign adv = !out_valid || out_ready;

    // Grant selection. A locked input keeps the grant even while its valid is
    // low, so a bubble inside a packet stalls the other input.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = prio;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = prio;
                end else if (in0_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b0;
                end else if (in1_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b1;
                end
            end
            LOCK0: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            LOCK1: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = prio;
            end
        endcase
    end

    // Ready is held low during reset so nothing is consumed and then dropped.
    assign in0_ready  = !RESET && adv && grant_valid && !grant_idx;
    assign in1_ready  = !RESET && adv && grant_valid && grant_idx;
    assign grant_data = grant_idx ? in1_data : in0_data;
    assign xfer       = grant_idx ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
    assign busy       = (state != IDLE);

    // Next state: a tail flit releases the lock and hands priority to the
    // other input; any other flit locks the output to its source.
    always_comb begin
        state_next = state;
        prio_next  = prio;
        if (xfer) begin
            if (grant_data[W-1]) begin
                state_next = IDLE;
                prio_next  = !grant_idx;
            end else begin
                state_next = grant_idx ? LOCK1 : LOCK0;
            end
        end
    end

    // State, priority and the single output register stage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            prio      <= RR_INIT;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            if (xfer) begin
                out_data  <= grant_data;
                out_src   <= grant_idx;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/flit_merge_arbiter.md
Name: flit_merge_arbiter

Overview:
Clocked two-input output-port arbiter for the synchronous router test shell. It merges two 9-bit flit streams (the Out0/Out1 sides of a 1-to-2 route decoder, or any two upstream ports) onto one output channel. Arbitration is round-robin at packet granularity: once an input wins, it holds the output until its tail flit passes. The block tags every output flit with its source. One register stage provides a 1-cycle latency and full throughput.

Parameters:
W, 9, flit width; bit W-1 is the tail flag and bits W-2:0 are the payload
RR_INIT, 0, input given priority after reset (0 or 1)

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
in0_data  in  W  flit from input 0
in0_valid  in  1  input 0 flit present
in0_ready  out  1  input 0 flit accepted this cycle
in1_data  in  W  flit from input 1
in1_valid  in  1  input 1 flit present
in1_ready  out  1  input 1 flit accepted this cycle
out_data  out  W  registered output flit
out_src  out  1  source input of out_data (0/1)
out_valid  out  1  output flit present
out_ready  in  1  downstream accepts
busy  out  1  a packet is locked (state != IDLE)

Behaviour:
- Transfer on any channel = valid && ready in the same cycle. The upstream side holds data and valid stable until the transfer. The block holds out_data, out_src and out_valid stable while out_valid && !out_ready.
- adv = !out_valid || out_ready, meaning the output register can load this cycle.
- State machine with states IDLE, LOCK0 and LOCK1. A prio register holds the index of the input preferred on a tie.
- Grant g, combinational:
  - In IDLE: if exactly one input is valid, g = that input. If both are valid, g = prio. If neither is valid, there is no grant.
  - In LOCKk: g = k, whether or not in_k is valid.
- in_g_ready = adv and the grant exists. The non-granted input's ready = 0. The ready signals may depend on in*_valid. No input ever sees ready while its own valid is low and another input is locked.
- On a transfer from input g:
  - out_data <= in_g_data and out_src <= g, and out_valid <= 1.
  - If the tail bit is 1: state <= IDLE, prio <= !g.
  - If the tail bit is 0: state <= LOCKg.
- If there is no transfer and out_ready is high: out_valid <= 0.
- A single-flit packet (head with tail = 1) never leaves IDLE.
- Latency is exactly 1 cycle from input transfer to out_valid. Sustained throughput is 1 flit/cycle, including back-to-back packets from alternating inputs, with no idle cycle between a tail and the next head.
- Locked input bubble: in LOCKk with in_k_valid = 0, the block stays in LOCKk and the other input stays stalled (ready = 0), even if it is valid.
- Output stall: while out_valid && !out_ready, both readies = 0 and the state and prio are unchanged.
- A valid input that drops before being granted is ignored. No grant is recorded for it.
- Reset:
  - State <= IDLE, prio <= RR_INIT, out_valid <= 0, out_data <= 0, out_src <= 0, busy = 0.
  - in0_ready and in1_ready are 0 during any cycle where RESET = 1.
  - Reset mid-packet discards the lock and any held flit. The next packet starts fresh with no recovery of the partial one.
- Combinational paths: in*_ready depends on out_valid, out_ready, state, prio and in*_valid only. No path runs from data to ready.

Test Plan:
1. Reset then idle: RESET = 1 for 2 cycles, then 0 with no valids. Required: out_valid = 0, busy = 0, in0_ready = in1_ready = 0 throughout.
2. Single-flit tie: in0 = 0x1AA and in1 = 0x155 both valid in the same cycle, out_ready = 1, RR_INIT = 0.
   - Cycle 1: out = 0x1AA with src 0.
   - Cycle 2: out = 0x155 with src 1.
   - prio ends at 0.
3. Packet lock: in0 sends a 3-flit packet 0x001, 0x002, 0x103 while in1 holds 0x1FF valid continuously. Required: the output sequence is 0x001, 0x002, 0x103 (src 0), then 0x1FF (src 1), with in1_ready = 0 until in0's tail transfers.
4. Bubble inside a lock: in0 sends head 0x010, drops valid for 2 cycles, then sends tail 0x111, with in1 valid throughout. Required: busy stays 1, in1 is not granted until after 0x111, and out_valid is 0 during the bubble.
5. Backpressure: out_ready = 0 for 4 cycles while out_valid = 1 with 0x0AB. Required: out_data stays at 0x0AB, both readies = 0, and no flit is lost or duplicated when out_ready returns to 1.
6. Reset mid-packet: assert RESET after the head of a 4-flit packet from in1. Required: the next cycle has busy = 0 and out_valid = 0. A subsequent single-flit 0x1C3 on in0 then passes with 1-cycle latency, src 0.
